// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port synchronous instruction memory
// between the core fetch path and the program-loader/debug port.
// Round-robin arbitration; hold_core keeps new fetches off the port
// while a program is being loaded. One transaction occupies two cycles
// (ACCESS drives the memory, RESP waits for its registered read data).
module imem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 20,
    parameter bit FIRST_OWNER = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_core,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_valid,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_valid,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    // Owner encoding used for both the current and the last owner:
    // 0 = fetch port, 1 = loader port.
    logic                r_owner;
    logic                r_lastOwner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_fRdata;
    logic [DATA_W-1:0]   r_lRdata;
    logic                r_fValid;
    logic                r_lValid;

    logic                w_fElig;
    logic                w_lElig;
    logic                w_arbEdge;
    logic                w_grant;
    logic                w_pickLoader;

    // State register; reset drops any in-flight transaction back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Arbitration, next-state selection and the per-state memory/grant outputs.
    always_comb begin
        w_fElig      = f_req & ~hold_core;
        w_lElig      = l_req;
        w_pickLoader = w_lElig & (~w_fElig | ~r_lastOwner);
        w_arbEdge    = (r_state == IDLE) || (r_state == RESP);
        w_grant      = w_arbEdge & (w_fElig | w_lElig);

        w_nextState  = r_state;
        m_en         = 1'b0;
        m_we         = 1'b0;
        f_gnt        = 1'b0;
        l_gnt        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                m_en        = 1'b1;
                m_we        = r_we;
                f_gnt       = ~r_owner;
                l_gnt       = r_owner;
                w_nextState = RESP;
            end
            RESP: begin
                w_nextState = w_grant ? ACCESS : IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Latch the winning request, capture read data at the end of RESP and
    // raise the owner's one-cycle valid pulse for reads only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= 1'b0;
            r_lastOwner <= ~FIRST_OWNER;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_fRdata    <= '0;
            r_lRdata    <= '0;
            r_fValid    <= 1'b0;
            r_lValid    <= 1'b0;
        end else begin
            r_fValid <= 1'b0;
            r_lValid <= 1'b0;
            if (w_grant) begin
                r_owner     <= w_pickLoader;
                r_lastOwner <= w_pickLoader;
                r_we        <= w_pickLoader & l_we;
                r_addr      <= w_pickLoader ? l_addr : f_addr;
                r_wdata     <= w_pickLoader ? l_wdata : '0;
            end
            if ((r_state == RESP) && !r_we) begin
                if (r_owner) begin
                    r_lRdata <= m_rdata;
                    r_lValid <= 1'b1;
                end else begin
                    r_fRdata <= m_rdata;
                    r_fValid <= 1'b1;
                end
            end
        end
    end

    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign f_rdata = r_fRdata;
    assign f_valid = r_fValid;
    assign l_rdata = r_lRdata;
    assign l_valid = r_lValid;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: drives imem_arbiter cycle by cycle from a table of
// {inputs, expected outputs} records, then walks the reset-in-ACCESS
// corner cases by hand. A behavioural single-port memory sits on the
// m_* side so read data comes back one cycle after m_en.
module tb_imem_arbiter;

    localparam logic [19:0] F0 = 20'h1A2B3;
    localparam logic [19:0] F1 = 20'h54321;
    localparam logic [19:0] LD = 20'hABCDE;

    typedef struct {
        logic        rst;
        logic        hold;
        logic        fReq;
        logic [7:0]  fAddr;
        logic        lReq;
        logic        lWe;
        logic [7:0]  lAddr;
        logic [19:0] lWdata;
        logic        eFGnt;
        logic        eLGnt;
        logic        eMEn;
        logic        eMWe;
        logic [7:0]  eMAddr;
        logic [19:0] eMWdata;
        logic        eFValid;
        logic [19:0] eFRdata;
        logic        eLValid;
        logic [19:0] eLRdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        hold_core;
    logic        f_req;
    logic [7:0]  f_addr;
    logic        f_gnt;
    logic [19:0] f_rdata;
    logic        f_valid;
    logic        l_req;
    logic        l_we;
    logic [7:0]  l_addr;
    logic [19:0] l_wdata;
    logic        l_gnt;
    logic [19:0] l_rdata;
    logic        l_valid;
    logic        m_en;
    logic        m_we;
    logic [7:0]  m_addr;
    logic [19:0] m_wdata;
    logic [19:0] m_rdata;

    logic [19:0] mem [256];

    int checks;
    int failures;
    vec_t vecs[$];

    imem_arbiter #(
        .ADDR_W(8),
        .DATA_W(20),
        .FIRST_OWNER(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hold_core(hold_core),
        .f_req(f_req),
        .f_addr(f_addr),
        .f_gnt(f_gnt),
        .f_rdata(f_rdata),
        .f_valid(f_valid),
        .l_req(l_req),
        .l_we(l_we),
        .l_addr(l_addr),
        .l_wdata(l_wdata),
        .l_gnt(l_gnt),
        .l_rdata(l_rdata),
        .l_valid(l_valid),
        .m_en(m_en),
        .m_we(m_we),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory: write or registered read on m_en.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                mem[m_addr] <= m_wdata;
            end else begin
                m_rdata <= mem[m_addr];
            end
        end
    end

    function automatic vec_t v(
        input logic rst_i, input logic hold_i, input logic fReq_i, input logic [7:0] fAddr_i,
        input logic lReq_i, input logic lWe_i, input logic [7:0] lAddr_i, input logic [19:0] lWdata_i,
        input logic eFGnt_i, input logic eLGnt_i, input logic eMEn_i, input logic eMWe_i,
        input logic [7:0] eMAddr_i, input logic [19:0] eMWdata_i,
        input logic eFValid_i, input logic [19:0] eFRdata_i,
        input logic eLValid_i, input logic [19:0] eLRdata_i);
        vec_t r;
        r.rst = rst_i;       r.hold = hold_i;       r.fReq = fReq_i;     r.fAddr = fAddr_i;
        r.lReq = lReq_i;     r.lWe = lWe_i;         r.lAddr = lAddr_i;   r.lWdata = lWdata_i;
        r.eFGnt = eFGnt_i;   r.eLGnt = eLGnt_i;     r.eMEn = eMEn_i;     r.eMWe = eMWe_i;
        r.eMAddr = eMAddr_i; r.eMWdata = eMWdata_i;
        r.eFValid = eFValid_i; r.eFRdata = eFRdata_i;
        r.eLValid = eLValid_i; r.eLRdata = eLRdata_i;
        return r;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t s);
        rst       = s.rst;
        hold_core = s.hold;
        f_req     = s.fReq;
        f_addr    = s.fAddr;
        l_req     = s.lReq;
        l_we      = s.lWe;
        l_addr    = s.lAddr;
        l_wdata   = s.lWdata;
    endtask

    task automatic checkOutput(input vec_t s, input string tag);
        checkField({tag, ".f_gnt"},   {31'd0, f_gnt},   {31'd0, s.eFGnt});
        checkField({tag, ".l_gnt"},   {31'd0, l_gnt},   {31'd0, s.eLGnt});
        checkField({tag, ".m_en"},    {31'd0, m_en},    {31'd0, s.eMEn});
        checkField({tag, ".m_we"},    {31'd0, m_we},    {31'd0, s.eMWe});
        if (s.eMEn) begin
            checkField({tag, ".m_addr"}, {24'd0, m_addr}, {24'd0, s.eMAddr});
        end
        if (s.eMWe) begin
            checkField({tag, ".m_wdata"}, {12'd0, m_wdata}, {12'd0, s.eMWdata});
        end
        checkField({tag, ".f_valid"}, {31'd0, f_valid}, {31'd0, s.eFValid});
        checkField({tag, ".f_rdata"}, {12'd0, f_rdata}, {12'd0, s.eFRdata});
        checkField({tag, ".l_valid"}, {31'd0, l_valid}, {31'd0, s.eLValid});
        checkField({tag, ".l_rdata"}, {12'd0, l_rdata}, {12'd0, s.eLRdata});
    endtask

    // Main sequence: table of per-cycle vectors, then hand-written reset cases.
    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 20'h0;
        end
        mem[8'h05] = F0;
        mem[8'h20] = F1;
        m_rdata    = 20'h0;
        applyStimulus(v(1,0,0,8'h00,0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0));

        //               rst hold fReq fAddr  lReq lWe lAddr  lWdata | fG lG en we mAddr  mWdata  fV fRdata  lV lRdata
        // Single fetch of 0x05, then loader write of 0x10 and read-back.
        vecs.push_back(v(0,0,1,8'h05,0,0,8'h00,20'h0,   0,0,0,0,8'h00,20'h0,  0,20'h0,0,20'h0));
        vecs.push_back(v(0,0,1,8'h05,0,0,8'h00,20'h0,   1,0,1,0,8'h05,20'h0,  0,20'h0,0,20'h0));
        vecs.push_back(v(0,0,0,8'h00,0,0,8'h00,20'h0,   0,0,0,0,8'h00,20'h0,  0,20'h0,0,20'h0));
        vecs.push_back(v(0,0,0,8'h00,1,1,8'h10,LD,      0,0,0,0,8'h00,20'h0,  1,F0,0,20'h0));
        vecs.push_back(v(0,0,0,8'h00,1,1,8'h10,LD,      0,1,1,1,8'h10,LD,     0,F0,0,20'h0));
        vecs.push_back(v(0,0,0,8'h00,1,0,8'h10,20'h0,   0,0,0,0,8'h00,20'h0,  0,F0,0,20'h0));
        vecs.push_back(v(0,0,0,8'h00,1,0,8'h10,20'h0,   0,1,1,0,8'h10,20'h0,  0,F0,0,20'h0));
        vecs.push_back(v(0,0,0,8'h00,0,0,8'h00,20'h0,   0,0,0,0,8'h00,20'h0,  0,F0,0,20'h0));
        // Both ports held: grants alternate F, L, F, L.
        vecs.push_back(v(0,0,1,8'h05,1,0,8'h10,20'h0,   0,0,0,0,8'h00,20'h0,  0,F0,1,LD));
        vecs.push_back(v(0,0,1,8'h05,1,0,8'h10,20'h0,   1,0,1,0,8'h05,20'h0,  0,F0,0,LD));
        vecs.push_back(v(0,0,1,8'h05,1,0,8'h10,20'h0,   0,0,0,0,8'h00,20'h0,  0,F0,0,LD));
        vecs.push_back(v(0,0,1,8'h05,1,0,8'h10,20'h0,   0,1,1,0,8'h10,20'h0,  1,F0,0,LD));
        vecs.push_back(v(0,0,1,8'h05,1,0,8'h10,20'h0,   0,0,0,0,8'h00,20'h0,  0,F0,0,LD));
        vecs.push_back(v(0,0,1,8'h05,1,0,8'h10,20'h0,   1,0,1,0,8'h05,20'h0,  0,F0,1,LD));
        vecs.push_back(v(0,0,1,8'h05,1,0,8'h10,20'h0,   0,0,0,0,8'h00,20'h0,  0,F0,0,LD));
        // hold_core with both requesting: loader keeps winning.
        vecs.push_back(v(0,1,1,8'h05,1,0,8'h10,20'h0,   0,1,1,0,8'h10,20'h0,  1,F0,0,LD));
        vecs.push_back(v(0,1,1,8'h05,1,0,8'h10,20'h0,   0,0,0,0,8'h00,20'h0,  0,F0,0,LD));
        vecs.push_back(v(0,1,1,8'h05,1,0,8'h10,20'h0,   0,1,1,0,8'h10,20'h0,  0,F0,1,LD));
        // hold drops: fetch of 0x20 wins; hold rises during its ACCESS.
        vecs.push_back(v(0,0,1,8'h20,1,0,8'h10,20'h0,   0,0,0,0,8'h00,20'h0,  0,F0,0,LD));
        vecs.push_back(v(0,1,1,8'h20,0,0,8'h00,20'h0,   1,0,1,0,8'h20,20'h0,  0,F0,1,LD));
        vecs.push_back(v(0,1,1,8'h20,0,0,8'h00,20'h0,   0,0,0,0,8'h00,20'h0,  0,F0,0,LD));
        vecs.push_back(v(0,1,1,8'h20,0,0,8'h00,20'h0,   0,0,0,0,8'h00,20'h0,  1,F1,0,LD));
        vecs.push_back(v(0,1,1,8'h20,0,0,8'h00,20'h0,   0,0,0,0,8'h00,20'h0,  0,F1,0,LD));
        vecs.push_back(v(0,0,0,8'h00,0,0,8'h00,20'h0,   0,0,0,0,8'h00,20'h0,  0,F1,0,LD));
        vecs.push_back(v(0,0,0,8'h00,0,0,8'h00,20'h0,   0,0,0,0,8'h00,20'h0,  0,F1,0,LD));

        repeat (3) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            checkOutput(vecs[i], $sformatf("row%0d", i));
            applyStimulus(vecs[i]);
        end

        // Reset during ACCESS of a loader read: no l_valid, everything back to 0.
        @(posedge clk); #1;
        applyStimulus(v(0,0,0,8'h00,1,0,8'h05,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0));
        @(posedge clk); #1;
        checkOutput(v(0,0,0,8'h00,0,0,8'h00,20'h0, 0,1,1,0,8'h05,20'h0, 0,F1,0,LD), "rstL.access");
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput(v(0,0,0,8'h00,0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0), "rstL.after");
        checkField("rstL.m_addr",  {24'd0, m_addr},  32'd0);
        checkField("rstL.m_wdata", {12'd0, m_wdata}, 32'd0);
        applyStimulus(v(0,0,1,8'h05,1,0,8'h10,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0));
        @(posedge clk); #1;
        checkOutput(v(0,0,0,8'h00,0,0,8'h00,20'h0, 1,0,1,0,8'h05,20'h0, 0,20'h0,0,20'h0), "rstL.tie");
        applyStimulus(v(0,0,0,8'h00,0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0));
        @(posedge clk); #1;
        checkOutput(v(0,0,0,8'h00,0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0), "rstL.resp");
        @(posedge clk); #1;
        checkOutput(v(0,0,0,8'h00,0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 1,F0,0,20'h0), "rstL.fvalid");

        // Reset during ACCESS of a fetch: the pointer must go back so fetch wins the tie.
        applyStimulus(v(0,0,1,8'h20,0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0));
        @(posedge clk); #1;
        checkOutput(v(0,0,0,8'h00,0,0,8'h00,20'h0, 1,0,1,0,8'h20,20'h0, 0,F0,0,20'h0), "rstF.access");
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput(v(0,0,0,8'h00,0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0), "rstF.after");
        applyStimulus(v(0,0,1,8'h05,1,0,8'h10,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0));
        @(posedge clk); #1;
        checkOutput(v(0,0,0,8'h00,0,0,8'h00,20'h0, 1,0,1,0,8'h05,20'h0, 0,20'h0,0,20'h0), "rstF.tie");
        applyStimulus(v(0,0,0,8'h00,0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0));
        @(posedge clk); #1;
        checkOutput(v(0,0,0,8'h00,0,0,8'h00,20'h0, 0,0,0,0,8'h00,20'h0, 0,20'h0,0,20'h0), "rstF.resp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port synchronous 20-bit instruction memory between two requesters: the core fetch path (from the control unit) and the program-loader/debug port.
- The loader can write programs into memory and read them back. The core fetches through the same memory port.
- Sits between control_unit/loader and the instruction memory array. Round-robin arbitration, with a hold input that locks out core fetches during program load.

Parameters:
- ADDR_W, 8, memory address width; matches the 8-bit PC.
- DATA_W, 20, instruction word width.
- FIRST_OWNER, 0, selects the tie-break winner after reset: 0 = fetch port wins, 1 = loader port wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hold_core  in  1  when 1, new f_req requests are not granted.
- f_req  in  1  fetch request; must be held with stable f_addr until f_gnt.
- f_addr  in  ADDR_W  fetch address.
- f_gnt  out  1  fetch grant, a 1-cycle pulse.
- f_rdata  out  DATA_W  fetched word; registered and held until the next fetch read completes.
- f_valid  out  1  1-cycle pulse; f_rdata is new in this cycle.
- l_req  in  1  loader request; must be held with l_we/l_addr/l_wdata stable until l_gnt.
- l_we  in  1  1 = write, 0 = read.
- l_addr  in  ADDR_W  loader address.
- l_wdata  in  DATA_W  loader write data.
- l_gnt  out  1  loader grant, a 1-cycle pulse.
- l_rdata  out  DATA_W  loader read data; registered and held.
- l_valid  out  1  1-cycle pulse on loader read completion only.
- m_en  out  1  memory enable.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; valid the cycle after the m_en cycle.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high.
  - On reset, all outputs go to 0 and the FSM goes to IDLE.
  - The last-owner pointer is set so that FIRST_OWNER wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any eligible request is present at the clock edge, arbitrate, latch owner/we/addr/wdata, and go to ACCESS.
  - ACCESS: m_en=1. m_we=1 only for a loader write. m_addr/m_wdata come from the latched registers. The owner's gnt=1 for this cycle only. Next state is always RESP.
  - RESP: m_en=0. For a read, m_rdata is captured into the owner's rdata at the end of RESP. At that same edge, arbitrate again: go to ACCESS if any eligible request is present, else go to IDLE.
- Eligibility rules:
  - f_req is eligible only if hold_core=0.
  - l_req is always eligible.
- Arbitration: round-robin.
  - If both ports are eligible, grant the port that was not the last owner.
  - If only one port is eligible, grant it.
  - The last-owner pointer updates on each grant.
- Valid pulse: x_valid goes high for 1 cycle in the cycle after RESP of a read. No valid pulse is issued for writes.
- Latency: request sampled at edge N → gnt in cycle N+1 → valid in cycle N+3. Peak throughput is one transaction per 2 cycles.
- Handshake:
  - The requester drops req, or presents a new request, in the cycle after gnt.
  - A req still high at the end of RESP is treated as a new request.
  - Inputs are sampled only at the arbitration edge; changes at other times are ignored.
- hold_core:
  - Asserting hold_core while a fetch is in ACCESS or RESP does not abort it; that fetch completes normally.
  - A pending f_req waits with no grant until hold_core falls.
- Read data: f_rdata/l_rdata keep their last value across writes and across the other port's reads.
- Reset mid-operation:
  - If rst is high in an ACCESS cycle, the memory operation in that cycle is still performed by the memory.
  - No valid pulse is issued, and the transaction is dropped.
  - The next cycle is IDLE with all outputs at 0.
- Address width: addresses pass through unmodified, ADDR_W wide; there is no wrap logic in this block.

Test Plan:
- Reset with FIRST_OWNER=0; then f_req=1 f_addr=0x05, with memory[0x05]=0x1A2B3 → f_gnt in cycle 1; m_en=1, m_addr=0x05 in cycle 1; f_valid in cycle 3 with f_rdata=0x1A2B3.
- Loader write l_we=1 l_addr=0x10 l_wdata=0xABCDE, then loader read of 0x10 → no l_valid for the write; l_rdata=0xABCDE on the read's l_valid; f_rdata unchanged.
- f_req and l_req both held continuously from reset → grants alternate F, L, F, L on cycles 1, 3, 5, 7, with m_en low on cycles 2, 4, 6.
- hold_core=1 with both requesting → only loader grants; f_gnt stays 0. Drop hold_core → fetch is granted at the next arbitration edge.
- Assert hold_core during a fetch's ACCESS → that fetch still returns f_valid; no further f_gnt is issued while hold_core is held.
- Assert rst during ACCESS of a loader read → no l_valid. The next cycle shows all outputs at 0 and IDLE. A subsequent tie goes to FIRST_OWNER.
